// File: rtl/if_fetch_if.sv
// if_fetch_if: the fetch unit's memory, redirect and consumer signals.
// Optional IF_FETCH_PERF_EN adds the perf_fetched / perf_stall counters.
interface if_fetch_if;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   // Fetch unit side
   modport master (
      input  fetch_en, redirect_valid, redirect_pc, mem_dout, inst_ready,
      output mem_addr, inst_valid, inst, inst_pc
`ifdef IF_FETCH_PERF_EN
      , output perf_fetched, perf_stall
`endif
   );

   // Memory / consumer / control side
   modport slave (
      output fetch_en, redirect_valid, redirect_pc, mem_dout, inst_ready,
      input  mem_addr, inst_valid, inst, inst_pc
`ifdef IF_FETCH_PERF_EN
      , input perf_fetched, perf_stall
`endif
   );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a 4-entry instruction buffer in
// front of a synchronous (1-cycle read latency) instruction memory.
// Optional macro IF_FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic        clk,
   input logic        rst_n,
   if_fetch_if.master bus
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;
   localparam int         DEPTH = 4;

   // The state is the current fetch_en level, so the very first cycle after
   // reset release with fetch_en high already issues a read.
   logic [0:0]  state;
   logic [31:0] pc_reg;
   logic        inflight_reg;
   logic [2:0]  count_reg;
   logic [1:0]  rd_ptr_reg;
   logic [1:0]  wr_ptr_reg;
   logic [31:0] buf_inst_reg [DEPTH];
   logic [31:0] buf_pc_reg   [DEPTH];
   logic [2:0]  occupancy;
   logic        issue;
   logic        push;
   logic        pop;
   logic        valid;

   assign state     = bus.fetch_en ? RUN : IDLE;
   // Entries already buffered plus the one read still in flight; a read is
   // only issued when its data is guaranteed a free slot.
   assign occupancy = count_reg + {2'b00, inflight_reg};
   assign issue     = (state == RUN) && !bus.redirect_valid && (occupancy < 3'd4);
   assign valid     = (count_reg != 3'd0);
   // A redirect discards the returning read and blocks the pop.
   assign push      = inflight_reg && !bus.redirect_valid;
   assign pop       = valid && bus.inst_ready && !bus.redirect_valid;

   assign bus.mem_addr   = pc_reg;
   assign bus.inst_valid = valid;
   assign bus.inst       = buf_inst_reg[rd_ptr_reg];
   assign bus.inst_pc    = buf_pc_reg[rd_ptr_reg];

   // Program counter, outstanding-read flag and buffer bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg       <= RESET_PC;
         inflight_reg <= 1'b0;
         count_reg    <= 3'd0;
         rd_ptr_reg   <= 2'd0;
         wr_ptr_reg   <= 2'd0;
      end else if (bus.redirect_valid) begin
         pc_reg       <= bus.redirect_pc;
         inflight_reg <= 1'b0;
         count_reg    <= 3'd0;
         wr_ptr_reg   <= rd_ptr_reg;
      end else begin
         inflight_reg <= issue;
         if (issue) pc_reg <= pc_reg + 32'd1;
         if (push)  wr_ptr_reg <= wr_ptr_reg + 2'd1;
         if (pop)   rd_ptr_reg <= rd_ptr_reg + 2'd1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Buffer storage; the pc of the returning read is one behind pc_reg
   // because pc_reg advanced when that read was issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_inst_reg[i] <= 32'd0;
            buf_pc_reg[i]   <= 32'd0;
         end
      end else if (push) begin
         buf_inst_reg[wr_ptr_reg] <= bus.mem_dout;
         buf_pc_reg[wr_ptr_reg]   <= pc_reg - 32'd1;
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic [31:0] fetched_reg;
   logic [31:0] stall_reg;

   assign bus.perf_fetched = fetched_reg;
   assign bus.perf_stall   = stall_reg;

   // Delivered-instruction and stalled-RUN-cycle counters (free-running wrap).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_reg <= 32'd0;
         stall_reg   <= 32'd0;
      end else begin
         if (valid && bus.inst_ready) fetched_reg <= fetched_reg + 32'd1;
         if ((state == RUN) && !issue && !bus.redirect_valid) stall_reg <= stall_reg + 32'd1;
      end
   end
`endif
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word index of the first instruction fetched after reset.
REQ-002 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port fetch_en  input  1  permits issue of new memory reads when high.
REQ-005 Port redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-006 Port redirect_pc  input  32  word index to restart at; sampled only when redirect_valid=1.
REQ-007 Port mem_addr  output  32  word index driven to the synchronous instruction memory; equals internal pc register.
REQ-008 Port mem_dout  input  32  memory read data, valid exactly one cycle after the matching mem_addr was issued.
REQ-009 Port inst_valid  output  1  head of instruction buffer is valid.
REQ-010 Port inst  output  32  instruction word at buffer head.
REQ-011 Port inst_pc  output  32  word index of inst.
REQ-012 Port inst_ready  input  1  consumer accepts head when inst_valid&&inst_ready.

Function
REQ-013 Addresses are word indices; sequential fetch increments pc by 1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-014 States: IDLE (fetch_en=0, no issue) and RUN (fetch_en=1); transition IDLE->RUN or RUN->IDLE follows fetch_en each cycle; an outstanding read still completes into the buffer.
REQ-015 Issue in a cycle iff state RUN, redirect_valid=0, and (buffer count + inflight) < 4; on issue pc<=pc+1 and inflight<=1 for the next cycle, else inflight<=0.
REQ-016 Instruction buffer: 4-entry FIFO of {inst, inst_pc}; push on cycle with inflight=1 (data=mem_dout, pc=issued pc), pop on inst_valid&&inst_ready; simultaneous push and pop leaves count unchanged.
REQ-017 Latency: read issued in cycle N -> captured at end of cycle N+1 -> inst_valid in cycle N+2; no combinational path mem_dout->inst.
REQ-018 Throughput: with inst_ready held high and fetch_en=1, one instruction per cycle sustained.
REQ-019 Buffer never overflows; inst_valid=0 whenever count=0; inst/inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-020 Redirect: in the redirect_valid cycle no issue, buffer flushed (count<=0), any inflight response discarded, pc<=redirect_pc; first issue at redirect_pc the following cycle; inst_valid=0 in the two cycles after the redirect cycle.
REQ-021 Redirect takes priority over pop, push and issue in the same cycle; redirect while in IDLE updates pc and flushes, with no issue until fetch_en=1.

Reset
REQ-022 rst_n low asynchronously sets pc=RESET_PC, count=0, inflight=0, state IDLE, inst_valid=0, inst=0, inst_pc=0.
REQ-023 Reset asserted mid-operation discards buffer contents and any outstanding read; first issue after release is RESET_PC.

Configuration
REQ-024 Macro IF_FETCH_PERF_EN defined: ports perf_fetched (output 32, count of inst_valid&&inst_ready cycles) and perf_stall (output 32, cycles in RUN with no issue and no redirect) exist, both reset to 0, wrap at 2^32.
REQ-025 Macro IF_FETCH_PERF_EN undefined: these ports and counters are absent; all other behaviour identical.

Verification
REQ-026 Memory words 0..3 = A0000001..A0000004, RESET_PC=0, fetch_en=1 from release, inst_ready=1 -> inst_valid first high in cycle 2 after release; inst A0000001, A0000002, A0000003, A0000004 with inst_pc 0,1,2,3 on consecutive cycles.
REQ-027 inst_ready=0 for 10 cycles -> exactly 4 entries buffered, mem_addr stops advancing at 4, inst holds A0000001; releasing inst_ready delivers 0..3 then 4.. with no gap or duplicate.
REQ-028 redirect_valid=1 with redirect_pc=2 while buffer holds entries -> inst_valid=0 for two cycles, next delivered inst A0000003 with inst_pc 2.
REQ-029 rst_n pulsed low mid-stream while inst_valid=1 -> inst_valid drops immediately, restart delivers A0000001 at inst_pc 0.
REQ-030 redirect_pc=32'hFFFF_FFFF -> inst_pc sequence FFFFFFFF, 00000000, 00000001.
REQ-031 With IF_FETCH_PERF_EN, 4 delivered instructions and 10 stalled RUN cycles -> perf_fetched=4, perf_stall=10.
